// File: rtl/amp_normalizer_if.sv
// Bus between the amplitude preprocessor and the amplitude normalizer.
// master drives the frame (amplitudes, sum, strobe), slave returns the shares.
interface amp_normalizer_if #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int BIN_QTY = 12
);
  localparam int S = W + D + $clog2(BIN_QTY);

  logic [BIN_QTY-1:0][W+D-1:0] noteAmplitudes_i;
  logic [S-1:0]                amplitudeSum_i;
  logic                        start;
  logic [BIN_QTY-1:0][D:0]     noteShares_o;
  logic                        data_v;
  logic                        busy;
  logic [7:0]                  dropped_o;

  modport master (
    output noteAmplitudes_i, amplitudeSum_i, start,
    input  noteShares_o, data_v, busy, dropped_o
  );

  modport slave (
    input  noteAmplitudes_i, amplitudeSum_i, start,
    output noteShares_o, data_v, busy, dropped_o
  );
endinterface

// File: rtl/amp_normalizer.sv
// Amplitude normalizer: divides each bin amplitude by the frame sum using one
// shared serial restoring divider, giving a Q1.D share per bin. A frame takes
// BIN_QTY*(D+1) divide cycles; results are published all at once.
module amp_normalizer #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int BIN_QTY = 12
) (
  input logic            clk,
  input logic            rst,
  amp_normalizer_if.slave bus
);
  localparam int S  = W + D + $clog2(BIN_QTY);
  localparam int BI = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
  localparam int BW = $clog2(D + 1);

  localparam logic [BI-1:0] LAST_BIN = BI'(BIN_QTY - 1);
  localparam logic [BW-1:0] TOP_BIT  = BW'(D);
  localparam logic [D:0]    SHARE_ONE = {1'b1, {D{1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                      state;
  logic [BIN_QTY-1:0][W+D-1:0] amp_snap;
  logic [S-1:0]                sum_snap;
  logic [BI-1:0]               bin_idx;
  logic [BW-1:0]               bit_cnt;
  logic [S:0]                  rem;
  logic [D:0]                  quot;
  logic                        clamp;
  logic [BIN_QTY-1:0][D:0]     shadow;

  logic [W+D-1:0] cur_amp;
  logic [S:0]     amp_ext;
  logic [S:0]     sum_ext;
  logic           bin_start;
  logic [S:0]     rem_in;
  logic           clamp_now;
  logic           take;
  logic [S:0]     rem_diff;
  logic [S:0]     rem_next;
  logic [D:0]     quot_next;
  logic [D:0]     share_final;

  assign bus.busy = (state != IDLE);

  // One restoring-divide step for the current bin; the first step of a bin
  // loads the remainder from the amplitude and decides the clamp.
  always_comb begin
    cur_amp     = amp_snap[bin_idx];
    amp_ext     = {{(S + 1 - (W + D)){1'b0}}, cur_amp};
    sum_ext     = {1'b0, sum_snap};
    bin_start   = (bit_cnt == TOP_BIT);
    rem_in      = bin_start ? amp_ext : rem;
    clamp_now   = bin_start ? (amp_ext >= sum_ext) : clamp;
    take        = (rem_in >= sum_ext);
    rem_diff    = take ? (rem_in - sum_ext) : rem_in;
    rem_next    = clamp_now ? '0 : (rem_diff << 1);
    quot_next   = bin_start ? '0 : quot;
    quot_next[bit_cnt] = take;
    share_final = clamp_now ? SHARE_ONE : quot_next;
  end

  // Frame sequencer, divider state, output publication and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      amp_snap         <= '0;
      sum_snap         <= '0;
      bin_idx          <= '0;
      bit_cnt          <= '0;
      rem              <= '0;
      quot             <= '0;
      clamp            <= 1'b0;
      shadow           <= '0;
      bus.noteShares_o <= '0;
      bus.data_v       <= 1'b0;
      bus.dropped_o    <= '0;
    end else begin
      bus.data_v <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            amp_snap <= bus.noteAmplitudes_i;
            sum_snap <= bus.amplitudeSum_i;
            bin_idx  <= '0;
            bit_cnt  <= TOP_BIT;
            if (bus.amplitudeSum_i == '0) begin
              shadow <= '0;
              state  <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          rem   <= rem_next;
          quot  <= quot_next;
          clamp <= clamp_now;
          if (bit_cnt == '0) begin
            shadow[bin_idx] <= share_final;
            bit_cnt         <= TOP_BIT;
            if (bin_idx == LAST_BIN) begin
              state <= DONE;
            end else begin
              bin_idx <= bin_idx + BI'(1);
            end
          end else begin
            bit_cnt <= bit_cnt - BW'(1);
          end
        end
        DONE: begin
          bus.noteShares_o <= shadow;
          bus.data_v       <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (bus.start && (state != IDLE) && (bus.dropped_o != 8'hFF)) begin
        bus.dropped_o <= bus.dropped_o + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_amp_normalizer.sv
// Self-checking bench for amp_normalizer: a table of frames run back to back,
// then hand sequences for overlap, mid-frame reset and drop-counter saturation.
module tb_amp_normalizer;
  localparam int W        = 6;
  localparam int D        = 10;
  localparam int BIN_QTY  = 12;
  localparam int S        = W + D + $clog2(BIN_QTY);
  localparam int N_VEC    = 6;
  localparam int WAIT_MAX = 400;

  typedef logic [BIN_QTY-1:0][W+D-1:0] amps_t;
  typedef logic [BIN_QTY-1:0][D:0]     shares_t;

  typedef struct {
    amps_t        amps;
    logic [S-1:0] sum;
    shares_t      shares;
    int           latency;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vec_t vecs[N_VEC];
  int   n_checks = 0;
  int   n_fail   = 0;

  amp_normalizer_if #(.W(W), .D(D), .BIN_QTY(BIN_QTY)) bus ();

  amp_normalizer #(.W(W), .D(D), .BIN_QTY(BIN_QTY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present a frame with start for one edge, then scramble the inputs so a
  // missing snapshot would corrupt the result. Returns just after edge 0.
  task automatic applyStimulus(input amps_t amps, input logic [S-1:0] sum);
    bus.noteAmplitudes_i = amps;
    bus.amplitudeSum_i   = sum;
    bus.start            = 1'b1;
    @(negedge clk);
    bus.start            = 1'b0;
    bus.noteAmplitudes_i = '1;
    bus.amplitudeSum_i   = S'(1);
  endtask

  // Count edges until data_v shows, starting from edge index k0.
  task automatic waitFrame(input int k0, output int lat, output logic busy_before);
    lat         = k0;
    busy_before = 1'b0;
    while (!bus.data_v && lat < WAIT_MAX) begin
      busy_before = bus.busy;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkShares(input string tag, input shares_t expected);
    for (int b = 0; b < BIN_QTY; b++) begin
      checkOutput($sformatf("%s share[%0d]", tag, b), 64'(bus.noteShares_o[b]),
                  64'(expected[b]));
    end
  endtask

  task automatic runFrame(input int i);
    int   lat;
    logic bb;
    applyStimulus(vecs[i].amps, vecs[i].sum);
    waitFrame(0, lat, bb);
    checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].latency));
    checkOutput($sformatf("vec%0d busy in DONE", i), 64'(bb), 64'd1);
    checkOutput($sformatf("vec%0d busy with data_v", i), 64'(bus.busy), 64'd0);
    checkShares($sformatf("vec%0d", i), vecs[i].shares);
  endtask

  initial begin
    int   lat;
    logic bb;
    int   pulses;

    for (int i = 0; i < N_VEC; i++) begin
      vecs[i].amps    = '0;
      vecs[i].shares  = '0;
      vecs[i].latency = BIN_QTY * (D + 1) + 1;
    end
    // Even split: two bins of 2.0 over 4.0.
    vecs[0].amps[0] = 16'd2048; vecs[0].amps[1] = 16'd2048; vecs[0].sum = 20'd4096;
    vecs[0].shares[0] = 11'd512; vecs[0].shares[1] = 11'd512;
    // Rounding toward zero: 1/3 and 2/3.
    vecs[1].amps[3] = 16'd1; vecs[1].amps[5] = 16'd2; vecs[1].sum = 20'd3;
    vecs[1].shares[3] = 11'd341; vecs[1].shares[5] = 11'd682;
    // Zero sum: shortcut straight to DONE.
    vecs[2].sum = 20'd0; vecs[2].latency = 1;
    // Clamp bin 0 (amp > sum), bin 1 computed normally.
    vecs[3].amps[0] = 16'd5000; vecs[3].amps[1] = 16'd1000; vecs[3].sum = 20'd4096;
    vecs[3].shares[0] = 11'd1024; vecs[3].shares[1] = 11'd250;
    // Odd divisor touching the last bin: 102400/107 and 7168/107.
    vecs[4].amps[11] = 16'd100; vecs[4].amps[4] = 16'd7; vecs[4].sum = 20'd107;
    vecs[4].shares[11] = 11'd957; vecs[4].shares[4] = 11'd66;
    // amp equal to sum at full scale clamps to exactly 1.0.
    vecs[5].amps[6] = 16'hFFFF; vecs[5].sum = 20'd65535;
    vecs[5].shares[6] = 11'd1024;

    bus.start            = 1'b0;
    bus.noteAmplitudes_i = '0;
    bus.amplitudeSum_i   = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset data_v", 64'(bus.data_v), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset dropped", 64'(bus.dropped_o), 64'd0);
    checkOutput("reset shares", 64'(bus.noteShares_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table frames run back to back: each start lands in the data_v cycle.
    for (int i = 0; i < N_VEC; i++) runFrame(i);
    checkOutput("back-to-back dropped", 64'(bus.dropped_o), 64'd0);

    // Overlap: a second start at edge 50 with other inputs is ignored.
    applyStimulus(vecs[0].amps, vecs[0].sum);
    repeat (49) @(negedge clk);
    bus.noteAmplitudes_i = vecs[1].amps;
    bus.amplitudeSum_i   = vecs[1].sum;
    bus.start            = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("overlap dropped", 64'(bus.dropped_o), 64'd1);
    checkOutput("overlap busy", 64'(bus.busy), 64'd1);
    waitFrame(50, lat, bb);
    checkOutput("overlap latency", 64'(lat), 64'(vecs[0].latency));
    checkShares("overlap first frame", vecs[0].shares);
    runFrame(1);
    checkOutput("overlap third start dropped", 64'(bus.dropped_o), 64'd1);

    // Reset in the middle of a frame abandons it without a data_v.
    applyStimulus(vecs[4].amps, vecs[4].sum);
    repeat (69) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset data_v", 64'(bus.data_v), 64'd0);
    checkOutput("midreset dropped", 64'(bus.dropped_o), 64'd0);
    checkOutput("midreset shares", 64'(bus.noteShares_o), 64'd0);
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    pulses = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.data_v) pulses++;
    end
    checkOutput("midreset no data_v", 64'(pulses), 64'd0);
    runFrame(4);

    // start held high: 133 drops per frame, then saturation at 255.
    bus.noteAmplitudes_i = vecs[0].amps;
    bus.amplitudeSum_i   = vecs[0].sum;
    bus.start            = 1'b1;
    @(negedge clk);
    repeat (149) @(negedge clk);
    checkOutput("held start dropped", 64'(bus.dropped_o), 64'd148);
    repeat (150) @(negedge clk);
    checkOutput("saturated dropped", 64'(bus.dropped_o), 64'd255);
    bus.start = 1'b0;
    repeat (150) @(negedge clk);
    checkOutput("saturated dropped holds", 64'(bus.dropped_o), 64'd255);
    checkShares("held start frame", vecs[0].shares);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
